video_capture_ctrl: RTL
=======================

Name: video_capture_ctrl

Overview:
- Sequences capture of one windowed frame from the AD9980 pixel stream into the input BRAM, then hands it to the processing block.
- Runs entirely in the pixel_clk_i domain; it samples hsync_i and vsync_i instead of using them as clocks.
- Produces the shift-register enable, BRAM row-write strobes and addresses, and the frame-level vld/rdy handshake.
- Counts captured, dropped and aborted frames for MicroBlaze test readout.

Parameters:
- LINE_LO, 196, first captured line index after the vsync fall.
- N_ROWS, 128, number of captured lines; must be ≤ 2^ADDR_W.
- COL_LO, 416, first captured column index after the hsync fall.
- N_COLS, 128, number of captured pixels per line.
- ADDR_W, 7, BRAM row-address width.
- CNT_W, 11, width of the line and column counters.

Ports:
- pixel_clk_i  in  1  pixel clock from AD9980.
- rst_i  in  1  reset.
- video_ACK_i  in  1  I2C configuration finished; level.
- hsync_i  in  1  active-low horizontal sync; asynchronous to the clock.
- vsync_i  in  1  active-low vertical sync; asynchronous to the clock.
- rdy_i  in  1  processing block can accept a frame.
- shift_en_o  out  1  current pixel is inside the capture window; shift it into the row register.
- wea_o  out  1  one-cycle BRAM row write strobe.
- addra_o  out  ADDR_W  BRAM row address.
- vld_o  out  1  complete frame is present in the BRAM.
- busy_o  out  1  state is CAPTURE.
- frame_cnt_o  out  16  frames handed off.
- drop_cnt_o  out  16  frame starts skipped because rdy_i was low.
- abort_cnt_o  out  16  captures cut short by an early vsync.

Behaviour:
- Reset: rst_i is asynchronous, active-high; clock is pixel_clk_i. On reset, all outputs are 0, state is IDLE, and both sync synchronizers load 2'b11.
- Sync path:
  - hsync_i and vsync_i each pass through a 2-flop synchronizer, then a third flop for edge detection.
  - hs_fall / vs_fall are single-cycle pulses, 3 cycles after the pin edge.
- Counters:
  - line_cnt clears on vs_fall and increments on hs_fall.
  - col_cnt clears on hs_fall and increments every cycle while synced hsync is high.
  - Both counters saturate at 2^CNT_W−1; they never wrap.
  - If hs_fall and vs_fall occur in the same cycle, vs_fall wins: line_cnt=0, col_cnt=0.
- FSM states and transitions:
  - IDLE: go to SYNC when video_ACK_i=1.
  - SYNC: wait for the first vs_fall, then go to ARMED. Frame boundaries are unknown until this happens.
  - ARMED: on vs_fall:
    - if rdy_i=1, go to CAPTURE with addra_o=0;
    - else drop_cnt_o+1 and stay in ARMED.
  - CAPTURE:
    - shift_en_o = (LINE_LO ≤ line_cnt < LINE_LO+N_ROWS) && (COL_LO ≤ col_cnt < COL_LO+N_COLS) && synced hsync high. The output is registered, so it lags the pixel by 1 cycle.
    - On hs_fall, if the line just finished was inside the window: wea_o=1 for exactly 1 cycle with addra_o equal to the row index. addra_o increments in the cycle after the strobe.
    - After the write with addra_o=N_ROWS−1: addra_o returns to 0, vld_o=1, frame_cnt_o+1, go to HANDOFF.
    - vs_fall before N_ROWS rows are written: abort_cnt_o+1, addra_o=0, no vld_o.
      - If rdy_i=1, restart CAPTURE on this same frame.
      - Else go to ARMED.
    - A change on rdy_i during CAPTURE is ignored.
  - HANDOFF:
    - vld_o is held high until rdy_i is sampled low (the consumer has taken the frame).
    - Then vld_o=0 and go to ARMED.
    - vs_fall during HANDOFF counts as a drop.
- video_ACK_i=0 in any state:
  - next cycle: state IDLE, wea_o=0, vld_o=0, addra_o=0;
  - frame_cnt_o, drop_cnt_o and abort_cnt_o are held.
- wea_o is never asserted outside CAPTURE, and never for more than 1 consecutive cycle.
- The statistics counters wrap modulo 2^16.

Decomposition:
- Package video_pkg holds:
  - the state enum {IDLE, SYNC, ARMED, CAPTURE, HANDOFF};
  - default window constants LINE_LO, N_ROWS, COL_LO, N_COLS;
  - CNT_W and ADDR_W.
- One sub-module, sync_edge_det: 2-flop synchronizer plus fall-edge pulse, instantiated twice (hsync, vsync).

Test Plan:
- Scaled parameters for the directed scenarios: LINE_LO=4, N_ROWS=4, COL_LO=10, N_COLS=8.
- Normal capture: video_ACK=1, rdy=1, 3 frames of 12 lines × 30 pixels -> per frame:
  - shift_en high for 8 cycles on lines 4..7;
  - 4 wea pulses at addr 0,1,2,3;
  - vld=1 after the 4th write;
  - after rdy low, frame_cnt=1.
- Not ready: rdy=0 across 2 vs_falls, then rdy=1 -> drop_cnt=2; capture starts on the 3rd frame.
- Short frame: vsync falls after line 6 -> abort_cnt=1, only 3 wea pulses, vld stays 0; the next full frame completes normally.
- Config drop: video_ACK deasserted mid-CAPTURE at addr=2 -> next cycle wea=0, vld=0, addr=0, state IDLE; re-assert -> SYNC, and capture waits for a fresh vs_fall.
- Simultaneous edges: hsync and vsync fall in the same cycle -> line_cnt=0, col_cnt=0, no wea.
- Reset: rst_i asserted during HANDOFF -> all outputs 0 immediately.

Source files
------------

// File: rtl/video_pkg.sv
// Shared types and default window geometry for the video capture controller.
package video_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        ARMED,
        CAPTURE,
        HANDOFF
    } state_t;

    localparam int LINE_LO = 196;
    localparam int N_ROWS  = 128;
    localparam int COL_LO  = 416;
    localparam int N_COLS  = 128;
    localparam int ADDR_W  = 7;
    localparam int CNT_W   = 11;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous active-low sync pin, plus a
// third flop that turns the synchronized falling edge into a one-cycle pulse.
module sync_edge_det (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic sync_o,
    output logic fall_o
);

    logic [1:0] r_sync;
    logic       r_prev;

    // Reset to the idle-high level so no spurious edge appears after reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync <= 2'b11;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[0], async_i};
            r_prev <= r_sync[1];
        end
    end

    assign sync_o = r_sync[1];
    assign fall_o = r_prev & ~r_sync[1];

endmodule

// File: rtl/video_capture_ctrl.sv
// Captures one windowed frame of the AD9980 pixel stream into the row BRAM
// and hands it to the processing block with a frame-level vld/rdy handshake.
module video_capture_ctrl #(
    parameter int LINE_LO = video_pkg::LINE_LO,
    parameter int N_ROWS  = video_pkg::N_ROWS,
    parameter int COL_LO  = video_pkg::COL_LO,
    parameter int N_COLS  = video_pkg::N_COLS,
    parameter int ADDR_W  = video_pkg::ADDR_W,
    parameter int CNT_W   = video_pkg::CNT_W
) (
    input  logic              pixel_clk_i,
    input  logic              rst_i,
    input  logic              video_ACK_i,
    input  logic              hsync_i,
    input  logic              vsync_i,
    input  logic              rdy_i,
    output logic              shift_en_o,
    output logic              wea_o,
    output logic [ADDR_W-1:0] addra_o,
    output logic              vld_o,
    output logic              busy_o,
    output logic [15:0]       frame_cnt_o,
    output logic [15:0]       drop_cnt_o,
    output logic [15:0]       abort_cnt_o
);

    import video_pkg::*;

    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_W:0]    L_LO     = (CNT_W+1)'(LINE_LO);
    localparam logic [CNT_W:0]    L_HI     = (CNT_W+1)'(LINE_LO + N_ROWS);
    localparam logic [CNT_W:0]    C_LO     = (CNT_W+1)'(COL_LO);
    localparam logic [CNT_W:0]    C_HI     = (CNT_W+1)'(COL_LO + N_COLS);
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(N_ROWS - 1);

    logic w_hs_sync;
    logic w_hs_fall;
    logic w_vs_sync;
    logic w_vs_fall;
    logic w_in_line;
    logic w_in_col;

    state_t             r_state;
    logic [CNT_W-1:0]   r_line_cnt;
    logic [CNT_W-1:0]   r_col_cnt;
    logic               r_shift_en;
    logic               r_wea;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_vld;
    logic [15:0]        r_frame_cnt;
    logic [15:0]        r_drop_cnt;
    logic [15:0]        r_abort_cnt;

    sync_edge_det u_hs_det (
        .clk_i   (pixel_clk_i),
        .rst_i   (rst_i),
        .async_i (hsync_i),
        .sync_o  (w_hs_sync),
        .fall_o  (w_hs_fall)
    );

    sync_edge_det u_vs_det (
        .clk_i   (pixel_clk_i),
        .rst_i   (rst_i),
        .async_i (vsync_i),
        .sync_o  (w_vs_sync),
        .fall_o  (w_vs_fall)
    );

    // Line/column position; vsync fall takes priority over a coincident hsync fall.
    always_ff @(posedge pixel_clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_line_cnt <= '0;
            r_col_cnt  <= '0;
        end else begin
            if (w_vs_fall) begin
                r_line_cnt <= '0;
            end else if (w_hs_fall && (r_line_cnt != CNT_MAX)) begin
                r_line_cnt <= r_line_cnt + 1'b1;
            end

            if (w_vs_fall || w_hs_fall) begin
                r_col_cnt <= '0;
            end else if (w_hs_sync && (r_col_cnt != CNT_MAX)) begin
                r_col_cnt <= r_col_cnt + 1'b1;
            end
        end
    end

    assign w_in_line = ({1'b0, r_line_cnt} >= L_LO) && ({1'b0, r_line_cnt} < L_HI);
    assign w_in_col  = ({1'b0, r_col_cnt}  >= C_LO) && ({1'b0, r_col_cnt}  < C_HI);

    always_ff @(posedge pixel_clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_shift_en  <= 1'b0;
            r_wea       <= 1'b0;
            r_addr      <= '0;
            r_vld       <= 1'b0;
            r_frame_cnt <= '0;
            r_drop_cnt  <= '0;
            r_abort_cnt <= '0;
        end else begin
            r_wea      <= 1'b0;
            r_shift_en <= video_ACK_i && (r_state == CAPTURE) &&
                          w_in_line && w_in_col && w_hs_sync;

            if (!video_ACK_i) begin
                r_state <= IDLE;
                r_addr  <= '0;
                r_vld   <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state <= SYNC;
                    end

                    SYNC: begin
                        if (w_vs_fall) begin
                            r_state <= ARMED;
                        end
                    end

                    ARMED: begin
                        if (w_vs_fall) begin
                            if (rdy_i) begin
                                r_state <= CAPTURE;
                                r_addr  <= '0;
                            end else begin
                                r_drop_cnt <= r_drop_cnt + 16'd1;
                            end
                        end
                    end

                    CAPTURE: begin
                        // A finished last row wins over a coincident vsync, which then starts an uncaptured frame.
                        if (r_wea && (r_addr == LAST_ROW)) begin
                            r_addr      <= '0;
                            r_vld       <= 1'b1;
                            r_frame_cnt <= r_frame_cnt + 16'd1;
                            r_state     <= HANDOFF;
                            if (w_vs_fall) begin
                                r_drop_cnt <= r_drop_cnt + 16'd1;
                            end
                        end else if (w_vs_fall) begin
                            r_abort_cnt <= r_abort_cnt + 16'd1;
                            r_addr      <= '0;
                            r_state     <= rdy_i ? CAPTURE : ARMED;
                        end else begin
                            if (r_wea) begin
                                r_addr <= r_addr + 1'b1;
                            end
                            if (w_hs_fall && w_in_line && !r_wea) begin
                                r_wea <= 1'b1;
                            end
                        end
                    end

                    HANDOFF: begin
                        if (w_vs_fall) begin
                            r_drop_cnt <= r_drop_cnt + 16'd1;
                        end
                        if (!rdy_i) begin
                            r_vld   <= 1'b0;
                            r_state <= ARMED;
                        end
                    end

                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign shift_en_o  = r_shift_en;
    assign wea_o       = r_wea;
    assign addra_o     = r_addr;
    assign vld_o       = r_vld;
    assign busy_o      = (r_state == CAPTURE);
    assign frame_cnt_o = r_frame_cnt;
    assign drop_cnt_o  = r_drop_cnt;
    assign abort_cnt_o = r_abort_cnt;

endmodule
